// File: rtl/traffic_light_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared types and encodings for the two-way intersection sequencer.
//   - state_e   : six-state phase cycle, 3-bit encoding (two codes unused)
//   - LT_*      : one-hot light-head encodings {red,yellow,green}
//   - CNT_W     : width of the phase countdown (durations 1..15)
//   - helpers   : phase successor and per-head light lookup
// -----------------------------------------------------------------------------
package traffic_pkg;

   localparam int CNT_W = 4;

   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

   typedef enum logic [2:0] {
      ST_NS_GREEN  = 3'd0,
      ST_NS_YELLOW = 3'd1,
      ST_ALLRED_NS = 3'd2,
      ST_EW_GREEN  = 3'd3,
      ST_EW_YELLOW = 3'd4,
      ST_ALLRED_EW = 3'd5
   } state_e;

   // Fixed ring; an all-red phase always sits between a yellow and the
   // opposite green, so the two heads can never both be non-red.
   function automatic state_e next_state(input state_e s);
      case (s)
         ST_NS_GREEN:  return ST_NS_YELLOW;
         ST_NS_YELLOW: return ST_ALLRED_NS;
         ST_ALLRED_NS: return ST_EW_GREEN;
         ST_EW_GREEN:  return ST_EW_YELLOW;
         ST_EW_YELLOW: return ST_ALLRED_EW;
         default:      return ST_NS_GREEN;
      endcase
   endfunction

   function automatic logic [2:0] light_ns_of(input state_e s);
      case (s)
         ST_NS_GREEN:  return LT_GRN;
         ST_NS_YELLOW: return LT_YEL;
         default:      return LT_RED;
      endcase
   endfunction

   function automatic logic [2:0] light_ew_of(input state_e s);
      case (s)
         ST_EW_GREEN:  return LT_GRN;
         ST_EW_YELLOW: return LT_YEL;
         default:      return LT_RED;
      endcase
   endfunction

   function automatic logic is_legal(input state_e s);
      return (s inside {ST_NS_GREEN, ST_NS_YELLOW, ST_ALLRED_NS,
                        ST_EW_GREEN, ST_EW_YELLOW, ST_ALLRED_EW});
   endfunction

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// -----------------------------------------------------------------------------
// traffic_light_sequencer_if
//   Board-facing bundle of the sequencer.
//   ped_req_ns/ew : debounced pedestrian buttons (level or pulse)
//   light_ns/ew   : one-hot {red,yellow,green} light heads
//   walk_ns/ew    : pedestrian WALK lamps
//   count         : ticks remaining in the current phase (1..15)
//   modport master : the sequencer (consumes buttons, drives lamps)
//   modport slave  : the board / display side
// -----------------------------------------------------------------------------
interface traffic_light_sequencer_if;
   import traffic_pkg::*;

   logic             ped_req_ns;
   logic             ped_req_ew;
   logic [2:0]       light_ns;
   logic [2:0]       light_ew;
   logic             walk_ns;
   logic             walk_ew;
   logic [CNT_W-1:0] count;

   modport master (
      input  ped_req_ns, ped_req_ew,
      output light_ns, light_ew, walk_ns, walk_ew, count
   );

   modport slave (
      output ped_req_ns, ped_req_ew,
      input  light_ns, light_ew, walk_ns, walk_ew, count
   );

endinterface

// File: rtl/traffic_light_sequencer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Free-running divider producing a one-cycle tick every TICK_DIV clocks.
//   clk   in  : system clock
//   reset in  : synchronous, active-high; restarts the count at 0
//   tick  out : high for the single cycle in which the count is TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   // Keep at least one bit so TICK_DIV==1 (tick every cycle) still elaborates.
   localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_light_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_light_sequencer
//   Two-way (NS/EW) intersection controller. Cycles
//   NS_GREEN -> NS_YELLOW -> ALLRED_NS -> EW_GREEN -> EW_YELLOW -> ALLRED_EW,
//   each phase lasting its duration in 1 s ticks, and serves latched
//   pedestrian requests with a WALK lamp at the start of the matching green.
//   clk    in  : system clock
//   reset  in  : synchronous, active-high
//   tl     if  : master modport (buttons in; light heads, walk lamps,
//                phase countdown out). All outputs are registered.
// -----------------------------------------------------------------------------
module traffic_light_sequencer
   import traffic_pkg::*;
#(
   parameter int TICK_DIV    = 100_000_000,
   parameter int GREEN_TIME  = 12,
   parameter int YELLOW_TIME = 3,
   parameter int ALLRED_TIME = 1,
   parameter int WALK_TIME   = 9
) (
   input  logic                      clk,
   input  logic                      reset,
   traffic_light_sequencer_if.master tl
);

   localparam logic [CNT_W-1:0] GRN_C    = CNT_W'(GREEN_TIME);
   localparam logic [CNT_W-1:0] YEL_C    = CNT_W'(YELLOW_TIME);
   localparam logic [CNT_W-1:0] ARD_C    = CNT_W'(ALLRED_TIME);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
   // Walk lamp is lit while count stays above this value.
   localparam logic [CNT_W-1:0] WALK_THR = CNT_W'(GREEN_TIME - WALK_TIME);

   logic             tick;
   state_e           state_q;
   state_e           nxt;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] cnt_dec;
   logic [2:0]       light_ns_q;
   logic [2:0]       light_ew_q;
   logic             walk_ns_q;
   logic             walk_ew_q;
   logic             req_ns_q;
   logic             req_ew_q;

   function automatic logic [CNT_W-1:0] dur(input state_e s);
      case (s)
         ST_NS_GREEN, ST_EW_GREEN:   return GRN_C;
         ST_NS_YELLOW, ST_EW_YELLOW: return YEL_C;
         default:                    return ARD_C;
      endcase
   endfunction

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_presc (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign nxt     = next_state(state_q);
   assign cnt_dec = count_q - ONE_C;

   // Single registered FSM: phase, countdown, lamps and request latches all
   // update on the same edge so the outputs are always mutually consistent.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_ALLRED_EW;
         count_q    <= ARD_C;
         light_ns_q <= LT_RED;
         light_ew_q <= LT_RED;
         walk_ns_q  <= 1'b0;
         walk_ew_q  <= 1'b0;
         req_ns_q   <= 1'b0;
         req_ew_q   <= 1'b0;
      end else begin
         // Latch requests every cycle; the green-entry branch below clears
         // them, and that later assignment wins on the entry edge.
         if (tl.ped_req_ns) req_ns_q <= 1'b1;
         if (tl.ped_req_ew) req_ew_q <= 1'b1;

         if (!is_legal(state_q)) begin
            state_q    <= ST_ALLRED_EW;
            count_q    <= ARD_C;
            light_ns_q <= LT_RED;
            light_ew_q <= LT_RED;
            walk_ns_q  <= 1'b0;
            walk_ew_q  <= 1'b0;
         end else if (tick) begin
            if (count_q != ONE_C) begin
               count_q <= cnt_dec;
               // Only the active green's lamp can be lit, so clearing both
               // is safe; outside green both are already low.
               if (cnt_dec <= WALK_THR) begin
                  walk_ns_q <= 1'b0;
                  walk_ew_q <= 1'b0;
               end
            end else begin
               state_q    <= nxt;
               count_q    <= dur(nxt);
               light_ns_q <= light_ns_of(nxt);
               light_ew_q <= light_ew_of(nxt);
               // Include the live button so a press on the entry cycle is served.
               walk_ns_q  <= (nxt == ST_NS_GREEN) && (req_ns_q || tl.ped_req_ns);
               walk_ew_q  <= (nxt == ST_EW_GREEN) && (req_ew_q || tl.ped_req_ew);
               if (nxt == ST_NS_GREEN) req_ns_q <= 1'b0;
               if (nxt == ST_EW_GREEN) req_ew_q <= 1'b0;
            end
         end
      end
   end

   assign tl.light_ns = light_ns_q;
   assign tl.light_ew = light_ew_q;
   assign tl.walk_ns  = walk_ns_q;
   assign tl.walk_ew  = walk_ew_q;
   assign tl.count    = count_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
module tb_traffic_light_sequencer;
   import traffic_pkg::*;

   localparam int         TD = 4;
   localparam logic [2:0] RD = 3'b100;
   localparam logic [2:0] YL = 3'b010;
   localparam logic [2:0] GN = 3'b001;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   traffic_light_sequencer_if tl_if();

   traffic_light_sequencer #(
      .TICK_DIV    (TD),
      .GREEN_TIME  (12),
      .YELLOW_TIME (3),
      .ALLRED_TIME (1),
      .WALK_TIME   (9)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .tl    (tl_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // snapshot = {light_ns, light_ew, walk_ns, walk_ew, count}
   typedef struct {
      int          due;
      logic [11:0] snap;
      string       nm;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   logic [11:0] act_snap;

   assign act_snap = {tl_if.light_ns, tl_if.light_ew, tl_if.walk_ns, tl_if.walk_ew, tl_if.count};

   task automatic expect_at(input int due, input logic [2:0] lns, input logic [2:0] lew,
                            input int wns, input int wew, input int cnt, input string nm);
      exp_t e;
      e.due  = due;
      e.snap = {lns, lew, 1'(wns), 1'(wew), 4'(cnt)};
      e.nm   = nm;
      sb.push_back(e);
   endtask

   task automatic check_snap(input bit ok, input string nm, input logic [11:0] want);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s @cyc %0d: got ns=%b ew=%b walk=%b%b cnt=%0d, want ns=%b ew=%b walk=%b%b cnt=%0d",
                    nm, cyc, act_snap[11:9], act_snap[8:6], act_snap[5], act_snap[4], act_snap[3:0],
                    want[11:9], want[8:6], want[5], want[4], want[3:0]);
   endtask

   task automatic check_inv(input bit ok, input string nm);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s @cyc %0d: got ns=%b ew=%b walk=%b%b cnt=%0d, rule violated",
                    nm, cyc, act_snap[11:9], act_snap[8:6], act_snap[5], act_snap[4], act_snap[3:0]);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Monitor: invariants every cycle, scoreboard entries whenever due.
   always @(negedge clk) begin
      if (cyc >= 1) begin
         check_inv(tl_if.count != 4'd0, "count_nonzero");
         check_inv($onehot(tl_if.light_ns) && $onehot(tl_if.light_ew), "lights_onehot");
         check_inv(tl_if.light_ns == RD || tl_if.light_ew == RD, "one_head_red");
         check_inv((!tl_if.walk_ns || tl_if.light_ns == GN) && (!tl_if.walk_ew || tl_if.light_ew == GN)
                   && !(tl_if.walk_ns && tl_if.walk_ew), "walk_needs_green");
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            check_snap(cur.due == cyc && act_snap === cur.snap, cur.nm, cur.snap);
         end
      end
   end

   initial begin
      int r, e, e2, e3, e4, r2, e5;
      tl_if.ped_req_ns = 1'b0;
      tl_if.ped_req_ew = 1'b0;
      repeat (3) @(negedge clk);
      r     = cyc;
      reset = 1'b0;
      e     = r + TD;

      // 1: reset values, first tick four cycles after release
      expect_at(r + 1,   RD, RD, 0, 0, 1,  "t1_reset_vals");
      expect_at(r + 3,   RD, RD, 0, 0, 1,  "t1_before_first_tick");
      expect_at(e,       GN, RD, 0, 0, 12, "t1_ns_green_entry");
      expect_at(e + 4,   GN, RD, 0, 0, 11, "t1_first_decrement");
      // 2: free-running phase boundaries
      expect_at(e + 47,  GN, RD, 0, 0, 1,  "t2_ns_green_last");
      expect_at(e + 48,  YL, RD, 0, 0, 3,  "t2_ns_yellow");
      expect_at(e + 60,  RD, RD, 0, 0, 1,  "t2_allred_ns");
      expect_at(e + 63,  RD, RD, 0, 0, 1,  "t2_allred_ns_last");
      expect_at(e + 64,  RD, GN, 0, 0, 12, "t2_ew_green");
      expect_at(e + 112, RD, YL, 0, 0, 3,  "t2_ew_yellow");
      expect_at(e + 124, RD, RD, 0, 0, 1,  "t2_allred_ew");
      e2 = e + 128;
      expect_at(e2,      GN, RD, 0, 0, 12, "t2_ns_green_again");
      // 3: EW request pulse during NS green, served at EW green
      expect_at(e2 + 20,  GN, RD, 0, 0, 7,  "t3_no_walk_in_ns_green");
      expect_at(e2 + 63,  RD, RD, 0, 0, 1,  "t3_no_walk_allred");
      expect_at(e2 + 64,  RD, GN, 0, 1, 12, "t3_walk_ew_on");
      expect_at(e2 + 99,  RD, GN, 0, 1, 4,  "t3_walk_ew_last");
      expect_at(e2 + 100, RD, GN, 0, 0, 3,  "t3_walk_ew_off");
      wait_cyc(e2 + 10); tl_if.ped_req_ew = 1'b1;
      wait_cyc(e2 + 11); tl_if.ped_req_ew = 1'b0;

      // 4: NS request exactly on the entry edge
      e3 = e2 + 128;
      e4 = e3 + 128;
      expect_at(e3,      GN, RD, 1, 0, 12, "t4_walk_ns_entry_req");
      expect_at(e3 + 35, GN, RD, 1, 0, 4,  "t4_walk_ns_last");
      expect_at(e3 + 36, GN, RD, 0, 0, 3,  "t4_walk_ns_off");
      expect_at(e4,      GN, RD, 0, 0, 12, "t4_latch_cleared");
      wait_cyc(e3 - 1); tl_if.ped_req_ns = 1'b1;
      wait_cyc(e3);     tl_if.ped_req_ns = 1'b0;

      // 5: reset in EW_YELLOW at count 2 (with a pending NS request that reset must drop)
      r2 = e4 + 119;
      e5 = r2 + TD;
      expect_at(e4 + 117, RD, YL, 0, 0, 2,  "t5_ew_yellow_cnt2");
      expect_at(e4 + 118, RD, RD, 0, 0, 1,  "t5_reset_mid_phase");
      expect_at(r2 + 3,   RD, RD, 0, 0, 1,  "t5_prescaler_restart");
      expect_at(e5,       GN, RD, 0, 0, 12, "t5_green_after_release");
      expect_at(e5 + 4,   GN, RD, 0, 0, 11, "t5_decrement");
      wait_cyc(e4 + 114); tl_if.ped_req_ns = 1'b1;
      wait_cyc(e4 + 115); tl_if.ped_req_ns = 1'b0;
      wait_cyc(e4 + 117); reset = 1'b1;
      wait_cyc(r2);       reset = 1'b0;

      // 6: random requests for ten full cycles; monitor enforces invariants
      wait_cyc(e5 + 5);
      for (int i = 0; i < 1280; i++) begin
         tl_if.ped_req_ns = ($urandom_range(0, 9) == 0);
         tl_if.ped_req_ew = ($urandom_range(0, 9) == 0);
         @(negedge clk);
      end
      tl_if.ped_req_ns = 1'b0;
      tl_if.ped_req_ew = 1'b0;

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         n_chk++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
